// File: rtl/pcie_phy_tx_pkg.sv
// Shared types for the PHY TX path: the 4:1 mux select encoding and the
// default SKP insertion interval.
package pcie_phy_tx_pkg;

  typedef enum logic [1:0] {
    SEL_TLP  = 2'b00,
    SEL_DLLP = 2'b01,
    SEL_OS   = 2'b10,
    SEL_IDLE = 2'b11
  } tx_sel_e;

  localparam int SKP_INTERVAL_DEFAULT = 1180;

endpackage

// File: rtl/pcie_skp_timer.sv
// SKP interval timer: raises skp_pending once per interval while the link is
// up and holds it until the scheduler starts an SKP ordered set.
module pcie_skp_timer #(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic clk,
  input  logic reset,
  input  logic link_up,
  input  logic skp_taken,
  output logic skp_pending
);

  localparam int CW = $clog2(SKP_INTERVAL);

  logic [CW-1:0] cnt;
  logic          expire;

  assign expire = link_up && (cnt == CW'(SKP_INTERVAL - 1));

  // An expiry coinciding with a grant wins, so the next SKP is still owed.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      skp_pending <= 1'b0;
    end else begin
      if (!link_up || expire) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
      if (expire)         skp_pending <= 1'b1;
      else if (skp_taken) skp_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/pcie_tx_mux_scheduler.sv
// PHY TX mux scheduler: arbitrates TLP, DLLP and ordered-set sources onto the
// 4:1 mux, never splitting a TLP, and inserts periodic SKP ordered sets.
module pcie_tx_mux_scheduler
  import pcie_phy_tx_pkg::*;
#(
  parameter int SKP_INTERVAL   = SKP_INTERVAL_DEFAULT,
  parameter int OS_BEATS       = 1,
  parameter int MAX_DLLP_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       link_up,
  input  logic       tlp_valid,
  input  logic       tlp_last,
  input  logic       dllp_valid,
  input  logic       os_req,
  output logic [1:0] sel,
  output logic       tlp_ready,
  output logic       dllp_ready,
  output logic       os_ready,
  output logic       os_is_skp
);

  localparam int BW  = (OS_BEATS > 1) ? $clog2(OS_BEATS) : 1;
  localparam int BCW = $clog2(MAX_DLLP_BURST + 1);

  tx_sel_e        state, next_state;
  logic [BW-1:0]  beat_cnt;
  logic [BCW-1:0] burst_cnt;
  logic           skp_q;
  logic           tlp_mid;
  logic           skp_pending;
  logic           arb, grant_skp, os_enter, dllp_grant, tlp_grant;

  pcie_skp_timer #(.SKP_INTERVAL(SKP_INTERVAL)) u_skp_timer (
    .clk         (clk),
    .reset       (reset),
    .link_up     (link_up),
    .skp_taken   (grant_skp),
    .skp_pending (skp_pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEL_IDLE;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      skp_q     <= 1'b0;
      tlp_mid   <= 1'b0;
    end else begin
      state <= next_state;
      if (os_enter) begin
        beat_cnt <= '0;
        skp_q    <= grant_skp;
      end else if (state == SEL_OS) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (!tlp_valid || tlp_grant)
        burst_cnt <= '0;
      else if (dllp_grant && burst_cnt != BCW'(MAX_DLLP_BURST))
        burst_cnt <= burst_cnt + 1'b1;
      if (state == SEL_TLP && tlp_valid)
        tlp_mid <= !tlp_last;
    end
  end

  // A TLP grant made on the previous packet's last beat may find no new
  // packet; with no beat yet accepted that TLP slot is also re-arbitrated.
  always_comb begin
    arb        = 1'b0;
    grant_skp  = 1'b0;
    next_state = state;
    case (state)
      SEL_IDLE, SEL_DLLP: arb = 1'b1;
      SEL_OS:             arb = (beat_cnt == BW'(OS_BEATS - 1));
      SEL_TLP:            arb = (tlp_valid && tlp_last) || (!tlp_valid && !tlp_mid);
      default:            arb = 1'b1;
    endcase
    if (arb) begin
      if (skp_pending && link_up) begin
        next_state = SEL_OS;
        grant_skp  = 1'b1;
      end else if (os_req) begin
        next_state = SEL_OS;
      end else if (link_up && dllp_valid &&
                   !(burst_cnt == BCW'(MAX_DLLP_BURST) && tlp_valid)) begin
        next_state = SEL_DLLP;
      end else if (link_up && tlp_valid) begin
        next_state = SEL_TLP;
      end else begin
        next_state = SEL_IDLE;
      end
    end
    os_enter   = arb && (next_state == SEL_OS);
    dllp_grant = arb && (next_state == SEL_DLLP);
    tlp_grant  = arb && (next_state == SEL_TLP);
  end

  always_comb begin
    sel        = state;
    tlp_ready  = (state == SEL_TLP) && tlp_valid;
    dllp_ready = (state == SEL_DLLP);
    os_ready   = (state == SEL_OS) && !skp_q;
    os_is_skp  = (state == SEL_OS) && skp_q;
  end

endmodule

// File: tb/tb_pcie_tx_mux_scheduler.sv
// Directed bench for pcie_tx_mux_scheduler: a per-cycle vector table plus
// hand-written SKP and link-down sequences.
module tb_pcie_tx_mux_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       link_up, tlp_valid, tlp_last, dllp_valid, os_req;
  logic [1:0] sel;
  logic       tlp_ready, dllp_ready, os_ready, os_is_skp;

  int num_compared   = 0;
  int num_mismatched = 0;

  // stim = {reset, link_up, tlp_valid, tlp_last, dllp_valid, os_req}
  // exp  = {sel[1:0], tlp_ready, dllp_ready, os_ready, os_is_skp}
  typedef struct packed {
    logic [5:0] stim;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  pcie_tx_mux_scheduler #(
    .SKP_INTERVAL   (32),
    .OS_BEATS       (2),
    .MAX_DLLP_BURST (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .link_up    (link_up),
    .tlp_valid  (tlp_valid),
    .tlp_last   (tlp_last),
    .dllp_valid (dllp_valid),
    .os_req     (os_req),
    .sel        (sel),
    .tlp_ready  (tlp_ready),
    .dllp_ready (dllp_ready),
    .os_ready   (os_ready),
    .os_is_skp  (os_is_skp)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [5:0] stim);
    {reset, link_up, tlp_valid, tlp_last, dllp_valid, os_req} = stim;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {sel, tlp_ready, dllp_ready, os_ready, os_is_skp};
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got sel/tr/dr/or/skp=%b_%b%b%b%b, expected %b_%b%b%b%b",
               name, got[5:4], got[3], got[2], got[1], got[0],
               exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One cycle: drive inputs just after the edge, check mid-cycle, advance.
  task automatic runCycle(input string name, input logic [5:0] stim, input logic [5:0] exp);
    applyStimulus(stim);
    #1;
    checkOutput(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(6'b100000);
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic [5:0] stim, input logic [5:0] exp);
    vecs.push_back('{stim: stim, exp: exp});
  endtask

  initial begin
    logic [5:0] e;
    logic       o;

    // 3-beat TLP, DLLP raised on beat 1 and served right after tlp_last
    addVec(6'b011000, 6'b110000);
    addVec(6'b011010, 6'b001000);
    addVec(6'b011010, 6'b001000);
    addVec(6'b011110, 6'b001000);
    addVec(6'b010000, 6'b010100);
    addVec(6'b010000, 6'b110000);
    addVec(6'b110000, 6'b110000);
    // DLLP and single-beat TLPs both held: DLLP x4, TLP, DLLP x4, TLP
    addVec(6'b011110, 6'b110000);
    for (int i = 0; i < 4; i++) addVec(6'b011110, 6'b010100);
    addVec(6'b011110, 6'b001000);
    for (int i = 0; i < 4; i++) addVec(6'b011110, 6'b010100);
    addVec(6'b011110, 6'b001000);
    addVec(6'b110000, 6'b010100);
    // link down with everything requested: only ordered sets go out
    addVec(6'b001111, 6'b110000);
    for (int i = 0; i < 3; i++) addVec(6'b001111, 6'b100010);
    addVec(6'b001110, 6'b100010);
    addVec(6'b001110, 6'b110000);
    addVec(6'b011110, 6'b110000);
    addVec(6'b011110, 6'b010100);
    addVec(6'b110000, 6'b010100);
    // reset on beat 2 of a 4-beat TLP, then the same packet afresh
    addVec(6'b011000, 6'b110000);
    addVec(6'b011000, 6'b001000);
    addVec(6'b111000, 6'b001000);
    addVec(6'b011000, 6'b110000);
    for (int i = 0; i < 3; i++) addVec(6'b011000, 6'b001000);
    addVec(6'b011110, 6'b001000);
    addVec(6'b010000, 6'b010100);
    addVec(6'b010000, 6'b110000);

    applyStimulus(6'b100000);
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) runCycle($sformatf("vec%0d", i), vecs[i].stim, vecs[i].exp);

    // Idle link: first SKP after 32 cycles; an LTSSM OS raised alongside waits
    doReset();
    for (int k = 0; k < 38; k++) begin
      o = (k >= 32 && k <= 35);
      if (k <= 32 || k == 37)     e = 6'b110000;
      else if (k == 33 || k == 34) e = 6'b100001;
      else                         e = 6'b100010;
      runCycle($sformatf("skp_os%0d", k), {1'b0, 1'b1, 3'b000, o}, e);
    end

    // Back-to-back single-beat TLPs: SKP only between packets, every 32 cycles
    doReset();
    for (int k = 0; k < 68; k++) begin
      if (k == 0)                                      e = 6'b110000;
      else if (k == 33 || k == 34 || k == 65 || k == 66) e = 6'b100001;
      else                                             e = 6'b001000;
      runCycle($sformatf("skp_tlp%0d", k), 6'b011100, e);
    end

    // Link held down keeps the SKP timer cleared; counting starts at link up
    doReset();
    for (int k = 0; k < 76; k++) begin
      e = (k == 73 || k == 74) ? 6'b100001 : 6'b110000;
      runCycle($sformatf("skp_link%0d", k), {1'b0, (k >= 40), 4'b0000}, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
